dcache_controller: RTL and testbench

Sequencing FSM for the data-cache path of the single-cycle RISC-V core. It sits between the core's decoded memory controls (MemRead/MemWrite), the cache tag-compare hit signal, and a slower handshaked main memory. It stalls the core on read misses while refilling a full line word by word. It also stalls on every store while the write-through to main memory completes. Policy is direct-mapped, write-through, no-write-allocate; the data and tag arrays live outside this block.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_perf_counter.sv | 20 ++
 rtl/dcache_controller.sv | 123 ++++++++++++
 tb/tb_dcache_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared states and defaults for the data-cache controller
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITE_MEM = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/dcache_perf_counter.sv
// rtl/dcache_perf_counter.sv - saturating enable counter for cache statistics
module dcache_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - data-cache sequencing FSM (optional counters: CACHE_CTRL_PERF_EN)
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
`ifdef CACHE_CTRL_PERF_EN
    , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           MemRead,
    input  logic                           MemWrite,
    input  logic                           hit,
    input  logic                           mem_ready,
    output logic                           stall,
    output logic                           cache_we,
    output logic                           refill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] refill_word,
    output logic                           mem_rd_req,
    output logic                           mem_wr_req
`ifdef CACHE_CTRL_PERF_EN
    , output logic [CNT_W-1:0]             perf_hits
    , output logic [CNT_W-1:0]             perf_misses
`endif
);

    localparam int WW = $clog2(BLOCK_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] word_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Refill beat offset: advances per returned word, wraps to 0 after the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (state_q == REFILL && mem_ready) begin
            word_q <= word_q + WW'(1);
        end else if (state_q == IDLE) begin
            word_q <= '0;
        end
    end

    // Next state and outputs; a load wins over a store when both are decoded
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        cache_we   = 1'b0;
        refill_we  = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead) begin
                    if (!hit) begin
                        state_d = REFILL;
                        stall   = 1'b1;
                    end
                end else if (MemWrite) begin
                    state_d  = WRITE_MEM;
                    stall    = 1'b1;
                    cache_we = hit;
                end
            end
            REFILL: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                refill_we  = mem_ready;
                if (mem_ready && word_q == LAST_WORD) begin
                    state_d = DONE;
                end
            end
            WRITE_MEM: begin
                stall      = 1'b1;
                mem_wr_req = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign refill_word = word_q;

`ifdef CACHE_CTRL_PERF_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state_q == IDLE) && MemRead && hit && !MemWrite;
    assign miss_inc = (state_q == IDLE) && MemRead && !hit;

    dcache_perf_counter #(.W(CNT_W)) u_hits (
        .clk   (clk),
        .rst   (rst),
        .en    (hit_inc),
        .count (perf_hits)
    );

    dcache_perf_counter #(.W(CNT_W)) u_misses (
        .clk   (clk),
        .rst   (rst),
        .en    (miss_inc),
        .count (perf_misses)
    );
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - randomized self-checking bench for dcache_controller
module tb_dcache_controller;

    localparam int BW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       MemRead = 1'b0;
    logic       MemWrite = 1'b0;
    logic       hit = 1'b0;
    logic       mem_ready = 1'b0;
    logic       stall;
    logic       cache_we;
    logic       refill_we;
    logic [1:0] refill_word;
    logic       mem_rd_req;
    logic       mem_wr_req;
`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int     errors = 0;
    int     checks = 0;
    longint exp_hits = 0;
    longint exp_misses = 0;

    always #5 clk = ~clk;

    dcache_controller #(.BLOCK_WORDS(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .hit         (hit),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .cache_we    (cache_we),
        .refill_we   (refill_we),
        .refill_word (refill_word),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req)
`ifdef CACHE_CTRL_PERF_EN
        , .perf_hits   (perf_hits)
        , .perf_misses (perf_misses)
`endif
    );

    // observed output bundle: {stall, cache_we, refill_we, mem_rd_req, mem_wr_req, refill_word}
    function automatic logic [6:0] outs();
        return {stall, cache_we, refill_we, mem_rd_req, mem_wr_req, refill_word};
    endfunction

    function automatic logic [6:0] expv(input bit s, input bit cw, input bit rwe,
                                        input bit rd, input bit wr, input int w);
        logic [1:0] wv;
        wv = w[1:0];
        return {s, cw, rwe, rd, wr, wv};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_perf(input string tag);
`ifdef CACHE_CTRL_PERF_EN
        checks++;
        if (perf_hits !== exp_hits[31:0]) begin
            errors++;
            $display("FAIL %s_perf_hits: got %0d want %0d", tag, perf_hits, exp_hits);
        end
        checks++;
        if (perf_misses !== exp_misses[31:0]) begin
            errors++;
            $display("FAIL %s_perf_misses: got %0d want %0d", tag, perf_misses, exp_misses);
        end
`endif
    endtask

    task automatic test_reset;
        logic [6:0] e;
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; hit = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        sample;
        e = expv(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs(), e);
        end
        test_perf("reset");
        tick;
    endtask

    task automatic test_read_hit(input int n);
        logic [6:0] e;
        for (int i = 0; i < n; i++) begin
            MemRead = 1'b1; MemWrite = 1'b0; hit = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            sample;
            e = expv(0, 0, 0, 0, 0, 0);
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL read_hit_cycle%0d: got %b want %b", i, outs(), e);
            end
            exp_hits++;
            tick;
        end
        MemRead = 1'b0; hit = 1'b0; mem_ready = 1'b0;
        test_perf("read_hit");
    endtask

    // g0: idle cycles before the first beat; g: idle cycles between later beats (upper bound when rnd)
    task automatic test_read_miss(input bit both, input int g0, input int g, input bit rnd);
        logic [6:0] e;
        int gap;
        MemRead = 1'b1; MemWrite = both; hit = 1'b0; mem_ready = 1'b0;
        sample;
        e = expv(1, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL miss_detect: got %b want %b", outs(), e);
        end
        exp_misses++;
        tick;
        for (int b = 0; b < BW; b++) begin
            gap = (b == 0) ? g0 : g;
            if (rnd) gap = $urandom_range(0, gap);
            for (int k = 0; k < gap; k++) begin
                mem_ready = 1'b0;
                sample;
                e = expv(1, 0, 0, 1, 0, b);
                checks++;
                if (outs() !== e) begin
                    errors++;
                    $display("FAIL miss_wait_beat%0d: got %b want %b", b, outs(), e);
                end
                tick;
            end
            mem_ready = 1'b1;
            sample;
            e = expv(1, 0, 1, 1, 0, b);
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL miss_beat%0d: got %b want %b", b, outs(), e);
            end
            tick;
        end
        mem_ready = 1'($urandom_range(0, 1));
        hit = 1'b1;
        sample;
        e = expv(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL miss_done: got %b want %b", outs(), e);
        end
        tick;
        MemRead = 1'b0; MemWrite = 1'b0; hit = 1'b0; mem_ready = 1'b0;
        test_perf("read_miss");
    endtask

    task automatic test_store(input bit h, input int delay);
        logic [6:0] e;
        int we_pulses;
        we_pulses = 0;
        MemRead = 1'b0; MemWrite = 1'b1; hit = h; mem_ready = 1'b0;
        sample;
        e = expv(1, h, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL store_issue: got %b want %b", outs(), e);
        end
        if (cache_we === 1'b1) we_pulses++;
        tick;
        for (int d = 0; d <= delay; d++) begin
            mem_ready = (d == delay);
            sample;
            e = expv(1, 0, 0, 0, 1, 0);
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL store_wait%0d: got %b want %b", d, outs(), e);
            end
            if (cache_we === 1'b1) we_pulses++;
            tick;
        end
        mem_ready = 1'b0;
        sample;
        e = expv(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL store_done: got %b want %b", outs(), e);
        end
        if (cache_we === 1'b1) we_pulses++;
        checks++;
        if (we_pulses != int'(h)) begin
            errors++;
            $display("FAIL store_cache_we_count: got %0d want %0d", we_pulses, int'(h));
        end
        tick;
        MemWrite = 1'b0; hit = 1'b0;
        test_perf("store");
    endtask

    task automatic test_stray_ready;
        logic [6:0] e;
        e = expv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            MemRead = 1'b0; MemWrite = 1'b0; hit = 1'($urandom_range(0, 1)); mem_ready = 1'b1;
            sample;
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL stray_ready%0d: got %b want %b", i, outs(), e);
            end
            tick;
        end
        MemRead = 1'b1; hit = 1'b1; mem_ready = 1'b0;
        sample;
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL stray_then_hit: got %b want %b", outs(), e);
        end
        exp_hits++;
        tick;
        MemRead = 1'b0; hit = 1'b0;
        test_perf("stray");
    endtask

    task automatic test_reset_mid_refill;
        logic [6:0] e;
        MemRead = 1'b1; MemWrite = 1'b0; hit = 1'b0; mem_ready = 1'b0;
        tick;
        mem_ready = 1'b1;
        repeat (2) tick;
        mem_ready = 1'b0;
        sample;
        e = expv(1, 0, 0, 1, 0, 2);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL pre_reset_refill: got %b want %b", outs(), e);
        end
        rst = 1'b1;
        MemRead = 1'b0;
        tick;
        e = expv(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL reset_mid_refill: got %b want %b", outs(), e);
        end
        exp_hits = 0; exp_misses = 0;
        test_perf("reset_mid");
        rst = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int kind;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                0: test_read_hit($urandom_range(1, 3));
                1: test_read_miss(1'($urandom_range(0, 1)), 3, 3, 1'b1);
                default: test_store(1'($urandom_range(0, 1)), $urandom_range(0, 3));
            endcase
        end
    endtask

    initial begin
        test_reset;
        test_read_hit(5);
        test_read_miss(1'b0, 2, 1, 1'b0);
        test_read_miss(1'b0, 0, 0, 1'b0);
        test_store(1'b1, 1);
        test_store(1'b1, 0);
        test_store(1'b0, $urandom_range(0, 4));
        test_read_miss(1'b1, 2, 2, 1'b1);
        test_stray_ready;
        test_back_to_back;
        test_reset_mid_refill;
        test_read_hit(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
